// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt request front end.
package irq_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned SYNC_MIN  = 2;
    localparam int unsigned SYNC_MAX  = 4;
    localparam logic        RST_LEVEL = 1'b0;

    typedef logic [NUM_CH-1:0] ch_vec_t;

    // One-hot channel select, all zero when not enabled.
    function automatic ch_vec_t idx_decode(input logic en, input logic [IDX_W-1:0] idx);
        ch_vec_t v;
        v = '0;
        if (en) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for one async line, followed by a rising-edge detector.
module sync_edge_det
    import irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    output logic o_rise_c
);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_stages
        $error("sync_edge_det: SYNC_STAGES must be in 2..4");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_LEVEL) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
            r_hist <= w_sync;
        end
    end

    assign o_rise_c = w_sync & ~r_hist;

endmodule

// File: rtl/irq_request_latch.sv
// Synchronises four async request lines into sticky pending bits with
// per-channel masking, index-based acknowledge and overflow tracking.
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_in,
    input  logic [NUM_CH-1:0] mask,
    input  logic              ack,
    input  logic [IDX_W-1:0]  ack_idx,
    input  logic              ovf_clr,
    output logic              d3,
    output logic              d2,
    output logic              d1,
    output logic              d0,
    output logic              any_pending,
    output logic [NUM_CH-1:0] overflow
);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_stages
        $error("irq_request_latch: SYNC_STAGES must be in 2..4");
    end

    ch_vec_t w_rise;
    ch_vec_t w_set;
    ch_vec_t w_clr;
    ch_vec_t w_ovf_evt;
    ch_vec_t w_pending_nxt;
    ch_vec_t w_ovf_nxt;
    ch_vec_t w_d;
    ch_vec_t r_pending;
    ch_vec_t r_ovf;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        sync_edge_det #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge_det (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_req    (req_in[gi]),
            .o_rise_c (w_rise[gi])
        );
    end

    // A masked edge never sets; set beats a same-cycle acknowledge.
    always_comb begin
        w_clr         = idx_decode(ack, ack_idx);
        w_set         = w_rise & mask;
        w_ovf_evt     = w_set & r_pending & ~w_clr;
        w_pending_nxt = w_set | (r_pending & ~w_clr);
        w_ovf_nxt     = w_ovf_evt | (r_ovf & ~{NUM_CH{ovf_clr}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_LEVEL) begin
            r_pending <= '0;
            r_ovf     <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    // Mask only hides held requests from the encoder; it never clears them.
    assign w_d         = r_pending & mask;
    assign d3          = w_d[3];
    assign d2          = w_d[2];
    assign d1          = w_d[1];
    assign d0          = w_d[0];
    assign any_pending = |w_d;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch with a queue-based scoreboard.
module tb_irq_request_latch;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic       ovf_clr;
    logic       d3, d2, d1, d0;
    logic       any_pending;
    logic [3:0] overflow;

    typedef struct {
        string      tag;
        logic [3:0] d;
        logic       any;
        logic [3:0] ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    irq_request_latch #(
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .mask        (mask),
        .ack         (ack),
        .ack_idx     (ack_idx),
        .ovf_clr     (ovf_clr),
        .d3          (d3),
        .d2          (d2),
        .d1          (d1),
        .d0          (d0),
        .any_pending (any_pending),
        .overflow    (overflow)
    );

    initial begin
        clk    = 1'b0;
        clk_en = 1'b1;
    end

    always #5 if (clk_en) clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] d, input logic [3:0] ovf);
        exp_t e;
        e.tag = tag;
        e.d   = d;
        e.any = |d;
        e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t       e;
        logic [3:0] obs_d;
        e     = sb.pop_front();
        obs_d = {d3, d2, d1, d0};
        n_tests++;
        assert (obs_d === e.d) else begin
            n_fail++;
            $error("FAIL %s d: got %b expected %b", e.tag, obs_d, e.d);
        end
        n_tests++;
        assert (any_pending === e.any) else begin
            n_fail++;
            $error("FAIL %s any_pending: got %b expected %b", e.tag, any_pending, e.any);
        end
        n_tests++;
        assert (overflow === e.ovf) else begin
            n_fail++;
            $error("FAIL %s overflow: got %b expected %b", e.tag, overflow, e.ovf);
        end
    endtask

    task automatic pulse_req(input int ch);
        req_in[ch] = 1'b1;
        tick(1);
        req_in[ch] = 1'b0;
        tick(3);
    endtask

    task automatic pulse_ack(input logic [1:0] idx);
        ack     = 1'b1;
        ack_idx = idx;
        tick(1);
        ack     = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req_in  = 4'b0000;
        mask    = 4'b1111;
        ack     = 1'b0;
        ack_idx = 2'd0;
        ovf_clr = 1'b0;

        #3;
        expect_out("reset", 4'b0000, 4'b0000); check_out();
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Two-clock latency from the sampling edge.
        req_in[1] = 1'b1;
        tick(1);
        req_in[1] = 1'b0;
        expect_out("rise1_edge0", 4'b0000, 4'b0000); check_out();
        tick(1);
        expect_out("rise1_edge1", 4'b0000, 4'b0000); check_out();
        tick(1);
        expect_out("rise1_edge2", 4'b0010, 4'b0000); check_out();
        tick(2);

        pulse_req(3);
        expect_out("pend_1010", 4'b1010, 4'b0000); check_out();
        pulse_ack(2'd3);
        expect_out("ack_ch3", 4'b0010, 4'b0000); check_out();
        pulse_ack(2'd1);
        expect_out("ack_ch1", 4'b0000, 4'b0000); check_out();

        pulse_req(2);
        expect_out("pend_ch2", 4'b0100, 4'b0000); check_out();
        pulse_req(2);
        expect_out("ovf_ch2", 4'b0100, 4'b0100); check_out();
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        expect_out("ovf_clr", 4'b0100, 4'b0000); check_out();
        pulse_ack(2'd2);
        expect_out("ack_ch2", 4'b0000, 4'b0000); check_out();
        pulse_ack(2'd2);
        expect_out("ack_idle", 4'b0000, 4'b0000); check_out();

        // Rise and ack on channel 0 land on the same edge.
        pulse_req(0);
        expect_out("pend_ch0", 4'b0001, 4'b0000); check_out();
        req_in[0] = 1'b1;
        tick(1);
        req_in[0] = 1'b0;
        tick(1);
        ack     = 1'b1;
        ack_idx = 2'd0;
        tick(1);
        ack = 1'b0;
        expect_out("set_wins", 4'b0001, 4'b0000); check_out();
        tick(2);
        expect_out("set_wins_hold", 4'b0001, 4'b0000); check_out();
        pulse_ack(2'd0);
        expect_out("ack_ch0", 4'b0000, 4'b0000); check_out();

        mask = 4'b0111;
        pulse_req(3);
        expect_out("masked_rise3", 4'b0000, 4'b0000); check_out();
        mask = 4'b1111;
        #1;
        expect_out("masked_no_pend3", 4'b0000, 4'b0000); check_out();
        pulse_req(2);
        expect_out("pend_ch2_b", 4'b0100, 4'b0000); check_out();
        mask = 4'b1011;
        #1;
        expect_out("mask_hide2", 4'b0000, 4'b0000); check_out();
        mask = 4'b1111;
        #1;
        expect_out("mask_reexpose2", 4'b0100, 4'b0000); check_out();
        mask = 4'b1011;
        pulse_ack(2'd2);
        mask = 4'b1111;
        #1;
        expect_out("ack_masked2", 4'b0000, 4'b0000); check_out();

        // Lines held high through reset register once after release.
        req_in = 4'b1111;
        tick(1);
        rst_n = 1'b0;
        #1;
        expect_out("held_in_reset", 4'b0000, 4'b0000); check_out();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        expect_out("release_2clk", 4'b0000, 4'b0000); check_out();
        tick(1);
        expect_out("release_3clk", 4'b1111, 4'b0000); check_out();
        tick(3);
        expect_out("release_single", 4'b1111, 4'b0000); check_out();
        req_in[0] = 1'b0;
        tick(3);
        req_in[0] = 1'b1;
        tick(3);
        expect_out("ovf_ch0", 4'b1111, 4'b0001); check_out();

        // Asynchronous reset with the clock stopped.
        clk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 4'b0000, 4'b0000); check_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
